dcmac_0_axis_pkt_gen_tx_fifo: RTL and testbench
===============================================

Name: dcmac_0_axis_pkt_gen_tx_fifo

Overview:
Downstream stage of the packet-generator data-merge pipeline. Captures each merged 192-byte word plus its delay-matched sideband (sop/eop/mty/id) and buffers it in a FIFO. Drives the DCMAC TX AXI-Stream with full tready backpressure. Returns an early almost-full to the generator scheduler to cover the in-flight pipeline, checks per-ID framing, and keeps packet/byte statistics.

Parameters:
DEPTH, 16, FIFO entries (power of 2, >=8)
AFULL_MARGIN, 6, free entries reserved for in-flight words (merge latency 4 + scheduler latency 2)
NUM_ID, 8, number of generator contexts (i_id width fixed at 3)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
i_vld  in  1  merged word valid (aligned with i_dat)
i_id  in  3  context ID of word
i_sop  in  1  first word of packet
i_eop  in  1  last word of packet
i_mty  in  8  empty bytes in eop word (0..191), ignored when !i_eop
i_dat  in  1536  merged data, byte i = bits [8i+7:8i]
o_afull  out  1  registered almost-full to generator
m_axis_tvalid  out  1  AXIS valid
m_axis_tready  in  1  AXIS ready
m_axis_tdata  out  1536  AXIS data
m_axis_tkeep  out  192  byte enables
m_axis_tlast  out  1  end of packet
m_axis_tid  out  3  context ID
i_clr_stats  in  1  synchronous statistics clear
o_pkt_cnt  out  32  packets sent
o_byte_cnt  out  48  bytes sent
o_ovf  out  1  sticky: word dropped on full FIFO
o_frm_err  out  1  sticky: per-ID sop/eop sequence violation
o_mty_err  out  1  sticky: eop word with mty>191

Behaviour:
- Reset (rst_n low, async): FIFO empty, all outputs 0, per-ID in-packet flags cleared, counters 0, sticky flags 0. Reset mid-packet discards all buffered words; there is no replay.
- Write: i_vld stores {id,sop,eop,mty,dat} unconditionally, with no ready toward the upstream stage.
- Write on full: a write is accepted if the FIFO is full and a read happens in the same cycle. Otherwise the word is dropped and o_ovf is set.
- o_afull: registered, equal to (occupancy after this cycle's updates) >= DEPTH-AFULL_MARGIN.
- Read/output stage: registered first-word-fall-through.
  - A word written at cycle T into an empty FIFO shows m_axis_tvalid=1 at T+2.
  - Transfer occurs on tvalid & tready.
  - While tvalid & !tready, tdata/tkeep/tlast/tid are held stable.
  - Back-to-back transfers sustain 1 word/cycle.
- tkeep: all ones when !eop. When eop, bits [191-mty:0] are set and the rest cleared.
- mty error: eop with mty>191 is clamped to mty=191 (tkeep=1 bit) and sets o_mty_err.
- tlast = eop; tid = id.
- Framing check at write time, one in-packet flag per ID:
  - sop while in-packet sets o_frm_err.
  - non-sop word while idle sets o_frm_err.
  - sop&eop in one word is a legal single-word packet.
  - The flag sets on sop and clears on eop.
  - Words are forwarded regardless of framing errors.
- Statistics (on transfer):
  - o_pkt_cnt += 1 when tlast.
  - o_byte_cnt += popcount(tkeep), i.e. 192 or 192-mty.
  - Both counters wrap modulo 2^width.
  - If i_clr_stats coincides with a transfer, clear applies first and the transfer is counted (result 1 / that beat's bytes).
- Sticky flags are cleared only by reset.
- Occupancy counter range 0..DEPTH; pointer wrap modulo DEPTH.

Test Plan:
- Single packet, ID 2: words sop, mid, eop with mty=92, tready=1 -> three beats, tid=2, last tkeep=100 ones, o_pkt_cnt=1, o_byte_cnt=484, first tvalid 2 cycles after first i_vld.
- tready=0 while writing 10 consecutive words -> o_afull rises after occupancy reaches 10. Releasing tready drains all 10 in order with no gaps and data held stable while stalled.
- Hold tready=0 and write 17 words with DEPTH=16 -> word 17 dropped, o_ovf=1, exactly 16 words later delivered.
- FIFO full, tready=1, i_vld in same cycle -> write accepted, o_ovf stays 0, occupancy remains 16.
- ID 1 sends sop, sop; ID 3 sends mid word while idle -> o_frm_err=1, all words still delivered. Interleaved legal IDs 0/5 -> no error.
- eop with mty=200 -> tkeep has only bit 0 set, o_mty_err=1. i_clr_stats on a tlast beat -> o_pkt_cnt=1. rst_n pulse mid-packet -> tvalid=0 immediately, counters 0.

Source files
------------

// File: rtl/dcmac_0_axis_pkt_gen_tx_fifo_if.sv
// DCMAC TX AXI-Stream bundle: one 192-byte beat with keep/last/id sideband.
// Latency: none, wires only.
// Backpressure: tready from the slave stalls the master; the master holds its beat while stalled.
//
// Ports (signals): tvalid, tready, tdata[1535:0], tkeep[191:0], tlast, tid[2:0].
interface dcmac_0_axis_pkt_gen_tx_fifo_if;
  logic          tvalid;
  logic          tready;
  logic [1535:0] tdata;
  logic [191:0]  tkeep;
  logic          tlast;
  logic [2:0]    tid;

  modport master (output tvalid, tdata, tkeep, tlast, tid, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tid, output tready);
endinterface

// File: rtl/dcmac_0_axis_pkt_gen_tx_fifo.sv
// Buffers merged generator words and drives them onto the DCMAC TX AXI-Stream, with framing checks and stats.
// Latency: a word written into an empty FIFO appears on m_axis two cycles later; 1 beat/cycle sustained.
// Backpressure: m_axis.tready stalls the output; the upstream has no ready, so o_afull warns early and full-FIFO writes are dropped.
//
// Ports:
//   clk, rst_n                    core clock, async active-low reset
//   i_vld/i_id/i_sop/i_eop/i_mty/i_dat   merged word plus delay-matched sideband
//   o_afull                       registered almost-full toward the generator scheduler
//   m_axis                        AXI-Stream master (tvalid/tready/tdata/tkeep/tlast/tid)
//   i_clr_stats, o_pkt_cnt, o_byte_cnt   statistics on transferred beats
//   o_ovf, o_frm_err, o_mty_err   sticky error flags, cleared only by reset
module dcmac_0_axis_pkt_gen_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int AFULL_MARGIN = 6,
  parameter int NUM_ID       = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_vld,
  input  logic [2:0]                           i_id,
  input  logic                                 i_sop,
  input  logic                                 i_eop,
  input  logic [7:0]                           i_mty,
  input  logic [1535:0]                        i_dat,
  output logic                                 o_afull,
  dcmac_0_axis_pkt_gen_tx_fifo_if.master       m_axis,
  input  logic                                 i_clr_stats,
  output logic [31:0]                          o_pkt_cnt,
  output logic [47:0]                          o_byte_cnt,
  output logic                                 o_ovf,
  output logic                                 o_frm_err,
  output logic                                 o_mty_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]  OCC_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]  OCC_AFULL = (AW+1)'(DEPTH - AFULL_MARGIN);
  localparam logic [191:0] KEEP_ALL  = '1;

  typedef struct packed {
    logic [2:0]    id;
    logic          eop;
    logic [7:0]    mty;   // already clamped to 0..191, zero on non-eop words
    logic [1535:0] dat;
  } ent_t;

  ent_t              mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  // occ counts every buffered word, including the one sitting in the output register
  logic [AW:0]       occ, occ_nxt;

  logic              out_vld;
  logic [1535:0]     out_dat;
  logic [191:0]      out_keep;
  logic              out_last;
  logic [2:0]        out_id;
  logic [7:0]        out_bytes;

  logic              xfer, full, wr_acc, mem_has, load;
  logic [7:0]        mty_c;
  ent_t              wr_ent, rd_ent;
  logic [NUM_ID-1:0] in_pkt;
  logic [31:0]       pkt_base;
  logic [47:0]       byte_base;

  always_comb begin
    xfer    = out_vld & m_axis.tready;
    full    = (occ == OCC_FULL);
    // a full FIFO still takes the word when the output frees a slot this cycle
    wr_acc  = i_vld & (~full | xfer);
    // words not yet moved into the output register
    mem_has = (occ != {{AW{1'b0}}, out_vld});
    load    = mem_has & (~out_vld | xfer);
    occ_nxt = occ + (AW+1)'(wr_acc) - (AW+1)'(xfer);

    mty_c      = (i_mty > 8'd191) ? 8'd191 : i_mty;
    wr_ent     = '0;
    wr_ent.id  = i_id;
    wr_ent.eop = i_eop;
    wr_ent.mty = i_eop ? mty_c : 8'd0;
    wr_ent.dat = i_dat;
    rd_ent     = mem[rd_ptr];

    // a clear coinciding with a transfer still counts that transfer
    pkt_base  = i_clr_stats ? 32'd0 : o_pkt_cnt;
    byte_base = i_clr_stats ? 48'd0 : o_byte_cnt;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      o_afull <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (load)   rd_ptr <= rd_ptr + 1'b1;
      occ     <= occ_nxt;
      o_afull <= (occ_nxt >= OCC_AFULL);
    end
  end

  // Output register: tkeep and beat byte count are precomputed here so the stats path stays short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld   <= 1'b0;
      out_dat   <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_id    <= '0;
      out_bytes <= '0;
    end else if (load) begin
      out_vld   <= 1'b1;
      out_dat   <= rd_ent.dat;
      out_keep  <= rd_ent.eop ? (KEEP_ALL >> rd_ent.mty) : KEEP_ALL;
      out_last  <= rd_ent.eop;
      out_id    <= rd_ent.id;
      out_bytes <= rd_ent.eop ? (8'd192 - rd_ent.mty) : 8'd192;
    end else if (xfer) begin
      out_vld   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_pkt_cnt  <= '0;
      o_byte_cnt <= '0;
    end else begin
      o_pkt_cnt  <= pkt_base + {31'd0, xfer & out_last};
      o_byte_cnt <= byte_base + (xfer ? {40'd0, out_bytes} : 48'd0);
    end
  end

  // Framing is checked on every presented word, whether or not the FIFO had room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_pkt    <= '0;
      o_ovf     <= 1'b0;
      o_frm_err <= 1'b0;
      o_mty_err <= 1'b0;
    end else begin
      if (i_vld & ~wr_acc)                   o_ovf     <= 1'b1;
      if (i_vld & i_eop & (i_mty > 8'd191))  o_mty_err <= 1'b1;
      if (i_vld) begin
        // sop while in-packet and non-sop while idle are both sop == in_pkt
        if (i_sop == in_pkt[i_id]) o_frm_err <= 1'b1;
        if (i_eop)                 in_pkt[i_id] <= 1'b0;
        else if (i_sop)            in_pkt[i_id] <= 1'b1;
      end
    end
  end

  assign m_axis.tvalid = out_vld;
  assign m_axis.tdata  = out_dat;
  assign m_axis.tkeep  = out_keep;
  assign m_axis.tlast  = out_last;
  assign m_axis.tid    = out_id;

endmodule

// File: tb/tb_dcmac_0_axis_pkt_gen_tx_fifo.sv
// Bench for dcmac_0_axis_pkt_gen_tx_fifo: directed scenarios plus random traffic against a queue model.
// Latency: model says a word is visible two cycles after its write once it reaches the queue head.
// Backpressure: tready is driven per cycle; stalled beats are compared against the held queue head.
module tb_dcmac_0_axis_pkt_gen_tx_fifo;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_vld = 1'b0;
  logic [2:0]    i_id = '0;
  logic          i_sop = 1'b0;
  logic          i_eop = 1'b0;
  logic [7:0]    i_mty = '0;
  logic [1535:0] i_dat = '0;
  logic          i_clr_stats = 1'b0;
  logic          o_afull;
  logic [31:0]   o_pkt_cnt;
  logic [47:0]   o_byte_cnt;
  logic          o_ovf, o_frm_err, o_mty_err;

  dcmac_0_axis_pkt_gen_tx_fifo_if axis ();

  always #5 clk = ~clk;

  dcmac_0_axis_pkt_gen_tx_fifo #(.DEPTH(16), .AFULL_MARGIN(6), .NUM_ID(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_vld(i_vld), .i_id(i_id), .i_sop(i_sop), .i_eop(i_eop), .i_mty(i_mty), .i_dat(i_dat),
    .o_afull(o_afull), .m_axis(axis), .i_clr_stats(i_clr_stats),
    .o_pkt_cnt(o_pkt_cnt), .o_byte_cnt(o_byte_cnt),
    .o_ovf(o_ovf), .o_frm_err(o_frm_err), .o_mty_err(o_mty_err)
  );

  typedef struct {
    int            wc;
    logic [2:0]    id;
    logic          eop;
    logic [7:0]    mty;
    logic [1535:0] dat;
  } exp_t;

  exp_t        q[$];
  int          cyc;
  logic [31:0] m_pkt;
  logic [47:0] m_byte;
  logic        m_ovf, m_frm, m_mty, m_afull;
  logic [7:0]  m_inpkt;
  int          compared = 0;
  int          mismatched = 0;

  task automatic chk(input string tag, input logic [1535:0] obs, input logic [1535:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs[191:0], exp_v[191:0]);
    end
  endtask

  function automatic logic [1535:0] rnd_dat();
    logic [1535:0] r;
    for (int i = 0; i < 48; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic int clamp_mty(input logic [7:0] mty);
    return (int'(mty) > 191) ? 191 : int'(mty);
  endfunction

  function automatic logic [191:0] exp_keep(input logic eop, input logic [7:0] mty);
    logic [191:0] k;
    for (int b = 0; b < 192; b++) k[b] = !eop || (b <= 191 - clamp_mty(mty));
    return k;
  endfunction

  function automatic bit head_vis();
    return (q.size() > 0) && (q[0].wc <= cyc - 2);
  endfunction

  task automatic model_reset();
    q.delete();
    m_pkt = '0; m_byte = '0; m_ovf = 0; m_frm = 0; m_mty = 0; m_afull = 0; m_inpkt = '0;
  endtask

  // One clock cycle: drive inputs, compare DUT state with the model, advance the model, clock.
  task automatic step(input logic vld, input logic [2:0] id, input logic sop, input logic eop,
                      input logic [7:0] mty, input logic rdy, input logic clr);
    logic [1535:0] d;
    bit vis, xfer;
    exp_t e;
    d = rnd_dat();
    i_vld = vld; i_id = id; i_sop = sop; i_eop = eop; i_mty = mty; i_dat = d;
    axis.tready = rdy; i_clr_stats = clr;

    vis = head_vis();
    chk("tvalid", axis.tvalid, vis);
    if (vis) begin
      chk("tdata", axis.tdata, q[0].dat);
      chk("tkeep", axis.tkeep, exp_keep(q[0].eop, q[0].mty));
      chk("tlast", axis.tlast, q[0].eop);
      chk("tid",   axis.tid,   q[0].id);
    end
    chk("afull",    o_afull,    m_afull);
    chk("pkt_cnt",  o_pkt_cnt,  m_pkt);
    chk("byte_cnt", o_byte_cnt, m_byte);
    chk("ovf",      o_ovf,      m_ovf);
    chk("frm_err",  o_frm_err,  m_frm);
    chk("mty_err",  o_mty_err,  m_mty);

    xfer = vis && rdy;
    if (clr) begin m_pkt = '0; m_byte = '0; end
    if (xfer) begin
      if (q[0].eop) m_pkt = m_pkt + 1;
      m_byte = m_byte + (q[0].eop ? 48'(192 - clamp_mty(q[0].mty)) : 48'd192);
      void'(q.pop_front());
    end
    if (vld) begin
      if (sop && m_inpkt[id])   m_frm = 1;
      if (!sop && !m_inpkt[id]) m_frm = 1;
      if (eop) m_inpkt[id] = 0; else if (sop) m_inpkt[id] = 1;
      if (eop && mty > 8'd191) m_mty = 1;
      if (q.size() < 16) begin
        e.wc = cyc; e.id = id; e.eop = eop; e.mty = mty; e.dat = d;
        q.push_back(e);
      end else begin
        m_ovf = 1;
      end
    end
    m_afull = (q.size() >= 10);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) step(0, 3'd0, 0, 0, 8'd0, rdy, 0);
  endtask

  initial begin
    logic [2:0] rid;
    logic       rv, re, rr, rc;
    logic [7:0] rm;
    axis.tready = 1'b0;
    model_reset();
    cyc = 0;
    #1;
    chk("rst_tvalid", axis.tvalid, 1'b0);
    chk("rst_afull", o_afull, 1'b0);
    chk("rst_pkt", o_pkt_cnt, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single three-word packet on ID 2, last word 100 bytes
    step(1, 3'd2, 1, 0, 8'd0, 1, 0);
    step(1, 3'd2, 0, 0, 8'd0, 1, 0);
    step(1, 3'd2, 0, 1, 8'd92, 1, 0);
    idle(6, 1);
    chk("t1_pkt", o_pkt_cnt, 32'd1);
    chk("t1_bytes", o_byte_cnt, 48'd484);

    // ten words into a stalled output, then drain with intermittent stalls
    for (int k = 0; k < 10; k++) step(1, 3'd4, k == 0, k == 9, 8'd17, 0, 0);
    chk("t2_afull", o_afull, 1'b1);
    for (int k = 0; k < 20; k++) step(0, 3'd0, 0, 0, 8'd0, (k % 3) != 1, 0);
    idle(3, 1);

    // fill to 16, write-through-full with a read, then a dropped 17th write
    for (int k = 0; k < 16; k++) step(1, 3'd6, k == 0, k == 15, 8'd40, 0, 0);
    step(1, 3'd7, 1, 1, 8'd5, 1, 0);
    chk("t4_ovf_clear", o_ovf, 1'b0);
    chk("t4_afull", o_afull, 1'b1);
    step(1, 3'd7, 1, 1, 8'd6, 0, 0);
    chk("t3_ovf_set", o_ovf, 1'b1);
    for (int k = 0; k < 30; k++) step(0, 3'd0, 0, 0, 8'd0, (k % 4) != 2, 0);
    idle(3, 1);

    // legal interleave on IDs 0 and 5, then framing violations on IDs 1 and 3
    step(1, 3'd0, 1, 0, 8'd0, 1, 0);
    step(1, 3'd5, 1, 0, 8'd0, 1, 0);
    step(1, 3'd0, 0, 0, 8'd0, 1, 0);
    step(1, 3'd5, 0, 1, 8'd10, 1, 0);
    step(1, 3'd0, 0, 1, 8'd0, 1, 0);
    chk("t5_no_frm", o_frm_err, 1'b0);
    step(1, 3'd1, 1, 0, 8'd0, 1, 0);
    step(1, 3'd1, 1, 0, 8'd0, 1, 0);
    step(1, 3'd1, 0, 1, 8'd3, 1, 0);
    step(1, 3'd3, 0, 0, 8'd0, 1, 0);
    chk("t5_frm", o_frm_err, 1'b1);
    idle(5, 1);

    // out-of-range mty, then a stats clear landing on that tlast beat
    step(1, 3'd2, 1, 1, 8'd200, 0, 0);
    for (int k = 0; k < 8; k++) if (!head_vis()) step(0, 3'd0, 0, 0, 8'd0, 0, 0);
    chk("t6_keep", axis.tkeep, 192'd1);
    chk("t6_mty_err", o_mty_err, 1'b1);
    step(0, 3'd0, 0, 0, 8'd0, 1, 1);
    chk("t6_clr_pkt", o_pkt_cnt, 32'd1);
    chk("t6_clr_bytes", o_byte_cnt, 48'd1);

    // random traffic, framing kept mostly legal, mty sometimes out of range
    for (int k = 0; k < 400; k++) begin
      rid = 3'($urandom_range(0, 7));
      rv  = ($urandom_range(0, 3) != 0);
      re  = ($urandom_range(0, 2) == 0);
      rm  = 8'($urandom_range(0, 255));
      rr  = ($urandom_range(0, 3) != 0);
      rc  = ($urandom_range(0, 49) == 0);
      step(rv, rid, !m_inpkt[rid], re, rm, rr, rc);
    end

    // reset in the middle of a packet with words buffered
    step(1, 3'd3, !m_inpkt[3], 0, 8'd0, 0, 0);
    step(1, 3'd3, 0, 0, 8'd0, 0, 0);
    step(1, 3'd3, 0, 0, 8'd0, 0, 0);
    i_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tvalid", axis.tvalid, 1'b0);
    chk("rst_mid_pkt", o_pkt_cnt, 32'd0);
    chk("rst_mid_bytes", o_byte_cnt, 48'd0);
    chk("rst_mid_ovf", o_ovf, 1'b0);
    model_reset();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    cyc++;
    step(1, 3'd3, 1, 1, 8'd0, 1, 0);
    idle(5, 1);
    chk("post_rst_pkt", o_pkt_cnt, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
